// File: rtl/spi_slave_pkg.sv
// Shared defaults and types for the SPI slave port.
package spi_slave_pkg;

  localparam int unsigned RX_WIDTH_DEF    = 24;
  localparam int unsigned TX_WIDTH_DEF    = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // SPI mode 0: CPOL=0, CPHA=0 (sample on leading edge, shift on trailing edge)
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic       SPI_CPOL = SPI_MODE[1];

  typedef enum logic [1:0] {
    FRAME_IDLE,
    FRAME_ACTIVE,
    FRAME_DONE
  } frame_state_t;

endpackage

// File: rtl/spi_slave_port_sync.sv
// Multi-stage bit synchroniser bringing an SPI pin into the clk domain.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift the pin value through the synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  always_comb q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave: one RX command word and one TX reply word per SS-low frame,
// with single-entry RX/TX handshake registers on the clk side.
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int unsigned RX_WIDTH    = RX_WIDTH_DEF,
  parameter int unsigned TX_WIDTH    = TX_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SPI_SCK,
  input  logic                SPI_SS,
  input  logic                SPI_MOSI,
  output logic                SPI_MISO,
  output logic                wr_buffer_free,
  input  logic                wr_en,
  input  logic [TX_WIDTH-1:0] wr_data,
  output logic                rd_data_available,
  input  logic                rd_ack,
  output logic [RX_WIDTH-1:0] rd_data
);

  localparam int unsigned CNTW = $clog2(RX_WIDTH + 1);
  localparam int unsigned RXIW = $clog2(RX_WIDTH);
  localparam int unsigned TXIW = $clog2(TX_WIDTH);
  localparam logic [CNTW-1:0] RX_LAST = CNTW'(RX_WIDTH - 1);
  localparam logic [CNTW-1:0] TX_BITS = CNTW'(TX_WIDTH);

  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d;
  logic sck_lead, sck_trail, ss_fall;

  frame_state_t           state;
  logic [CNTW-1:0]        bit_cnt;
  logic [RX_WIDTH-1:0]    rx_shift;
  logic [RX_WIDTH-1:0]    rx_next;
  logic [TX_WIDTH-1:0]    tx_latch;
  logic [TX_WIDTH-1:0]    tx_buf;
  logic                   tx_in_use;
  logic [RXIW-1:0]        rx_idx;
  logic [TXIW-1:0]        tx_idx;
  logic                   tx_bit;
  logic                   bit_take, frame_start, frame_done, frame_abort;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .reset(reset), .d(SPI_SCK),  .q(sck_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss   (.clk(clk), .reset(reset), .d(SPI_SS),   .q(ss_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset(reset), .d(SPI_MOSI), .q(mosi_s));

  // Previous synchronised SCK/SS for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_d <= 1'b0;
      ss_d  <= 1'b0;
    end else begin
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  // Edge decode and frame events; bit n of the frame maps to word bit n^7
  // (byte n/8 in place, MSB-first inside the byte), for both RX and TX.
  always_comb begin
    sck_lead    = (sck_s ^ SPI_CPOL) & ~(sck_d ^ SPI_CPOL);
    sck_trail   = ~(sck_s ^ SPI_CPOL) & (sck_d ^ SPI_CPOL);
    ss_fall     = ss_d & ~ss_s;
    rx_idx      = RXIW'(bit_cnt) ^ RXIW'(7);
    tx_idx      = TXIW'(bit_cnt) ^ TXIW'(7);
    rx_next     = rx_shift;
    rx_next[rx_idx] = mosi_s;
    tx_bit      = (bit_cnt < TX_BITS) ? tx_latch[tx_idx] : 1'b0;
    frame_start = (state == FRAME_IDLE) && ss_fall;
    bit_take    = (state == FRAME_ACTIVE) && !ss_s && sck_lead;
    frame_done  = bit_take && (bit_cnt == RX_LAST);
    frame_abort = (state == FRAME_ACTIVE) && ss_s;
  end

  // Frame FSM: bit counter, RX assembly, TX word latch and MISO driver
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FRAME_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_latch <= '0;
      SPI_MISO <= 1'b0;
    end else begin
      case (state)
        FRAME_IDLE: begin
          SPI_MISO <= 1'b0;
          if (frame_start) begin
            state    <= FRAME_ACTIVE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_latch <= wr_buffer_free ? '0 : tx_buf;
            SPI_MISO <= ~wr_buffer_free & tx_buf[7];
          end
        end
        FRAME_ACTIVE: begin
          if (ss_s) begin
            state    <= FRAME_IDLE;
            SPI_MISO <= 1'b0;
          end else if (sck_lead) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == RX_LAST) state <= FRAME_DONE;
          end else if (sck_trail) begin
            SPI_MISO <= tx_bit;
          end
        end
        FRAME_DONE: begin
          if (ss_s) begin
            state    <= FRAME_IDLE;
            SPI_MISO <= 1'b0;
          end else if (sck_trail) begin
            SPI_MISO <= 1'b0;
          end
        end
        default: state <= FRAME_IDLE;
      endcase
    end
  end

  // RX/TX handshake registers; ack is applied before a coincident completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data           <= '0;
      rd_data_available <= 1'b0;
      wr_buffer_free    <= 1'b1;
      tx_buf            <= '0;
      tx_in_use         <= 1'b0;
    end else begin
      if (frame_done && (!rd_data_available || rd_ack)) begin
        rd_data           <= rx_next;
        rd_data_available <= 1'b1;
      end else if (rd_ack) begin
        rd_data_available <= 1'b0;
      end

      if (frame_done && tx_in_use) begin
        wr_buffer_free <= 1'b1;
        tx_in_use      <= 1'b0;
      end else if (frame_start && !wr_buffer_free) begin
        tx_in_use <= 1'b1;
      end else if (frame_abort) begin
        tx_in_use <= 1'b0;
      end

      // Only accepted while free, which cannot coincide with a release above
      if (wr_en && wr_buffer_free) begin
        tx_buf         <= wr_data;
        wr_buffer_free <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: transaction-level model plus
// per-cycle compare of the handshake outputs while the port is idle.
module tb_spi_slave_port;
  import spi_slave_pkg::*;

  localparam int unsigned RXW = RX_WIDTH_DEF;
  localparam int unsigned TXW = TX_WIDTH_DEF;
  localparam int unsigned SYN = SYNC_STAGES_DEF;

  logic           clk = 1'b0;
  logic           reset;
  logic           sck, ss, mosi, miso;
  logic           free, wr_en, avail, rd_ack;
  logic [TXW-1:0] wr_data;
  logic [RXW-1:0] rd_data;

  always #5 clk = ~clk;

  spi_slave_port #(.RX_WIDTH(RXW), .TX_WIDTH(TXW), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .reset(reset),
    .SPI_SCK(sck), .SPI_SS(ss), .SPI_MOSI(mosi), .SPI_MISO(miso),
    .wr_buffer_free(free), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data_available(avail), .rd_ack(rd_ack), .rd_data(rd_data)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          chk_en = 1'b0;

  // Reference model state
  logic [RXW-1:0] m_rd    = '0;
  bit             m_avail = 1'b0;
  bit             m_free  = 1'b1;
  logic [TXW-1:0] m_buf   = '0;

  logic [RXW-1:0] got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nclk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle compare against the model while the port is quiescent
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data_available", 32'(avail), 32'(m_avail));
      check("rd_data", 32'(rd_data), 32'(m_rd));
      check("wr_buffer_free", 32'(free), 32'(m_free));
      check("miso_idle", 32'(miso), 32'd0);
    end
  end

  task automatic do_write(input logic [TXW-1:0] d);
    chk_en = 1'b0;
    wr_data = d;
    wr_en = 1'b1;
    nclk(1);
    wr_en = 1'b0;
    if (m_free) begin
      m_buf  = d;
      m_free = 1'b0;
    end
    nclk(1);
    chk_en = 1'b1;
  endtask

  task automatic do_ack();
    chk_en = 1'b0;
    rd_ack = 1'b1;
    nclk(1);
    rd_ack = 1'b0;
    m_avail = 1'b0;
    nclk(1);
    chk_en = 1'b1;
  endtask

  // Master side of one frame; byte k of word goes out MSB-first, MISO bits
  // are reassembled the same way so a full reply reads back as a word.
  task automatic do_frame(input logic [RXW-1:0] word, input int unsigned nbits,
                          input bit raise_ss, input bit ack_last,
                          output logic [RXW-1:0] miso_word);
    logic [RXW-1:0] reply_exp;
    chk_en = 1'b0;
    miso_word = '0;
    reply_exp = m_free ? '0 : RXW'(m_buf);
    ss = 1'b0;
    nclk(4);
    for (int unsigned n = 0; n < nbits; n++) begin
      int unsigned k;
      int unsigned j;
      k = n / 8;
      j = n % 8;
      mosi = word[8*k + 7 - j];
      nclk(4);
      miso_word[8*k + 7 - j] = miso;
      sck = 1'b1;
      if (ack_last && (n == nbits - 1)) begin
        nclk(SYN);
        rd_ack = 1'b1;
        nclk(1);
        rd_ack = 1'b0;
        nclk(3 - SYN);
      end else begin
        nclk(4);
      end
      sck = 1'b0;
    end
    nclk(4);
    if (raise_ss) begin
      ss = 1'b1;
      nclk(6);
    end
    if (nbits == RXW) begin
      check("miso_reply", 32'(miso_word), 32'(reply_exp));
      if (ack_last) m_avail = 1'b0;
      if (!m_avail) begin
        m_rd    = word;
        m_avail = 1'b1;
      end
      m_free = 1'b1;
    end
    if (raise_ss) chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    wr_en = 1'b0; wr_data = '0; rd_ack = 1'b0;
    nclk(3);
    check("reset_free", 32'(free), 32'd1);
    check("reset_avail", 32'(avail), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    reset = 1'b1;
    nclk(4);
    chk_en = 1'b1;

    // Populate state, then reset in the middle of bit 10
    do_write(16'h5A5A);
    do_frame(24'hA5C3E1, RXW, 1'b1, 1'b0, got);
    check("lit_reply_5a5a", 32'(got), 32'h005A5A);
    do_write(16'h7777);
    do_frame(24'hFFFFFF, 9, 1'b0, 1'b0, got);
    mosi = 1'b1;
    nclk(4);
    sck = 1'b1;
    nclk(2);
    reset = 1'b0;
    nclk(2);
    sck = 1'b0;
    nclk(2);
    check("midreset_free", 32'(free), 32'd1);
    check("midreset_avail", 32'(avail), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    check("midreset_miso", 32'(miso), 32'd0);
    m_avail = 1'b0; m_rd = '0; m_free = 1'b1;
    ss = 1'b1;
    nclk(2);
    reset = 1'b1;
    nclk(6);
    chk_en = 1'b1;

    // Command 0x02,0x34,0x12 then ack
    do_frame(24'h123402, RXW, 1'b1, 1'b0, got);
    check("lit_rd_123402", 32'(rd_data), 32'h123402);
    check("lit_avail_set", 32'(avail), 32'd1);
    check("lit_reply_empty", 32'(got), 32'h000000);
    do_ack();
    check("lit_avail_acked", 32'(avail), 32'd0);
    check("lit_rd_held", 32'(rd_data), 32'h123402);

    // TX word, second write while full is ignored
    do_write(16'hBEEF);
    check("lit_free_loaded", 32'(free), 32'd0);
    do_write(16'h1111);
    do_frame(24'h000010, RXW, 1'b1, 1'b0, got);
    check("lit_reply_beef", 32'(got), 32'h00BEEF);
    check("lit_free_released", 32'(free), 32'd1);
    do_ack();

    // Abort after 12 bits keeps the TX word for the following full frame
    do_write(16'hC0DE);
    do_frame(24'hFFFFFF, 12, 1'b1, 1'b0, got);
    check("lit_abort_avail", 32'(avail), 32'd0);
    check("lit_abort_free", 32'(free), 32'd0);
    do_frame(24'h000005, RXW, 1'b1, 1'b0, got);
    check("lit_rd_000005", 32'(rd_data), 32'h000005);
    check("lit_reply_c0de", 32'(got), 32'h00C0DE);
    do_ack();

    // Overrun drops the second word; ack coinciding with completion stores it
    do_frame(24'h000004, RXW, 1'b1, 1'b0, got);
    do_frame(24'h070004, RXW, 1'b1, 1'b0, got);
    check("lit_overrun_rd", 32'(rd_data), 32'h000004);
    check("lit_overrun_avail", 32'(avail), 32'd1);
    do_frame(24'h070004, RXW, 1'b1, 1'b1, got);
    check("lit_ack_complete_rd", 32'(rd_data), 32'h070004);
    check("lit_ack_complete_avail", 32'(avail), 32'd1);
    do_ack();

    // Randomised mix of operations against the model
    for (int unsigned it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(TXW'($urandom));
        1: do_ack();
        2: do_frame(RXW'($urandom), RXW, 1'b1, 1'($urandom_range(0, 1)), got);
        default: do_frame(RXW'($urandom), $urandom_range(1, RXW - 1), 1'b1, 1'b0, got);
      endcase
      nclk(2);
    end

    chk_en = 1'b0;
    nclk(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
